// File: rtl/prog_sequencer.sv
// prog_sequencer
//   Owns program flow around the combinational instruction decoder: program counter,
//   decoder mode register and previous-instruction register. Runs the Start/Done
//   handshake with the bench, gates architectural writes to the RUN phase, counts
//   RUN cycles and enforces a watchdog timeout.
//
// Ports
//   Clk                 in   clock, rising edge
//   Reset_n             in   asynchronous active-low reset
//   Start               in   high = hold/load, falling edge = begin run
//   BranchEn            in   decoder: take BranchTarget instead of PC+1
//   BranchTarget        in   decoder: absolute branch destination
//   NextState           in   decoder: mode for the next instruction
//   PrevInstructionOut  in   decoder: current instruction word to retain
//   Ack                 in   decoder: program finished
//   ProgCtr             out  instruction ROM address
//   CurrState           out  registered decoder mode
//   PrevInstruction     out  registered previous instruction word
//   Run                 out  write-enable gate, high only in RUN
//   Done                out  program finished or timed out, held until next Start
//   Timeout             out  Done was caused by the watchdog
//   CycleCount          out  saturating count of RUN cycles of the current/last program

module prog_sequencer #(
   parameter int unsigned PC_W       = 9,
   parameter int unsigned CYC_W      = 16,
   parameter int unsigned MAX_CYCLES = 4096
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             BranchEn,
   input  logic [PC_W-1:0]  BranchTarget,
   input  logic [1:0]       NextState,
   input  logic [8:0]       PrevInstructionOut,
   input  logic             Ack,
   output logic [PC_W-1:0]  ProgCtr,
   output logic [1:0]       CurrState,
   output logic [8:0]       PrevInstruction,
   output logic             Run,
   output logic             Done,
   output logic             Timeout,
   output logic [CYC_W-1:0] CycleCount
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   // MAX_CYCLES == 0 disables the watchdog; WdLast is then unused.
   localparam bit              WdEn   = (MAX_CYCLES != 0);
   localparam logic [CYC_W-1:0] WdLast = CYC_W'(MAX_CYCLES - 1);

   state_e state;
   logic   wd_hit;

   assign wd_hit = WdEn && (CycleCount == WdLast);
   assign Run    = (state == StRun);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state           <= StIdle;
         ProgCtr         <= '0;
         CurrState       <= 2'b00;
         PrevInstruction <= '0;
         Done            <= 1'b0;
         Timeout         <= 1'b0;
         CycleCount      <= '0;
      end else if (Start) begin
         // Start wins in every state: enter/stay in LOAD with a clean program context.
         state           <= StLoad;
         ProgCtr         <= '0;
         CurrState       <= 2'b00;
         PrevInstruction <= '0;
         Done            <= 1'b0;
         Timeout         <= 1'b0;
         CycleCount      <= '0;
      end else begin
         unique case (state)
            StIdle, StDone: ;
            StLoad: state <= StRun;
            StRun: begin
               // Counted on every RUN cycle, including the one that ends the run.
               if (CycleCount != '1) CycleCount <= CycleCount + CYC_W'(1);
               if (Ack) begin
                  state <= StDone;
                  Done  <= 1'b1;
               end else if (wd_hit) begin
                  state   <= StDone;
                  Done    <= 1'b1;
                  Timeout <= 1'b1;
               end else begin
                  ProgCtr         <= BranchEn ? BranchTarget : ProgCtr + PC_W'(1);
                  CurrState       <= NextState;
                  PrevInstruction <= PrevInstructionOut;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;
   localparam int MAXC = 8;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Start = 1'b0;
   logic        BranchEn = 1'b0;
   logic [8:0]  BranchTarget = '0;
   logic [1:0]  NextState = '0;
   logic [8:0]  PrevInstructionOut = '0;
   logic        Ack = 1'b0;
   logic [8:0]  ProgCtr;
   logic [1:0]  CurrState;
   logic [8:0]  PrevInstruction;
   logic        Run;
   logic        Done;
   logic        Timeout;
   logic [15:0] CycleCount;

   int checks = 0;
   int errors = 0;

   prog_sequencer #(
      .PC_W       (9),
      .CYC_W      (16),
      .MAX_CYCLES (MAXC)
   ) dut (
      .Clk                (Clk),
      .Reset_n            (Reset_n),
      .Start              (Start),
      .BranchEn           (BranchEn),
      .BranchTarget       (BranchTarget),
      .NextState          (NextState),
      .PrevInstructionOut (PrevInstructionOut),
      .Ack                (Ack),
      .ProgCtr            (ProgCtr),
      .CurrState          (CurrState),
      .PrevInstruction    (PrevInstruction),
      .Run                (Run),
      .Done               (Done),
      .Timeout            (Timeout),
      .CycleCount         (CycleCount)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       start, ack, br;
      logic [8:0] tgt;
      logic [1:0] ns;
      logic [8:0] pio;
      logic [8:0] pc;
      logic [1:0] cs;
      logic [8:0] prev;
      logic       run, done, tmo;
      logic [15:0] cyc;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] cs,
                          input logic [31:0] pv, input logic [31:0] r, input logic [31:0] d,
                          input logic [31:0] t, input logic [31:0] c);
      chk({tag, ".pc"}, 32'(ProgCtr), pc);
      chk({tag, ".cs"}, 32'(CurrState), cs);
      chk({tag, ".prev"}, 32'(PrevInstruction), pv);
      chk({tag, ".run"}, 32'(Run), r);
      chk({tag, ".done"}, 32'(Done), d);
      chk({tag, ".tmo"}, 32'(Timeout), t);
      chk({tag, ".cyc"}, 32'(CycleCount), c);
   endtask

   task automatic drive(input logic s, input logic a, input logic b, input logic [8:0] t,
                        input logic [1:0] n, input logic [8:0] p);
      Start = s; Ack = a; BranchEn = b; BranchTarget = t; NextState = n; PrevInstructionOut = p;
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   // Start pulse of one cycle, then release: returns in the first RUN cycle at PC 0.
   task automatic go_run;
      drive(1, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      // Table: start/ack/br/tgt/ns/pio -> pc/cs/prev/run/done/tmo/cyc after the edge.
      tbl[0]  = '{1, 0, 0, 9'h000, 2'd0, 9'h000, 9'h000, 2'd0, 9'h000, 0, 0, 0, 16'd0};
      tbl[1]  = '{1, 0, 0, 9'h000, 2'd0, 9'h000, 9'h000, 2'd0, 9'h000, 0, 0, 0, 16'd0};
      tbl[2]  = '{1, 0, 0, 9'h000, 2'd0, 9'h000, 9'h000, 2'd0, 9'h000, 0, 0, 0, 16'd0};
      tbl[3]  = '{0, 0, 0, 9'h000, 2'd0, 9'h000, 9'h000, 2'd0, 9'h000, 1, 0, 0, 16'd0};
      tbl[4]  = '{0, 0, 0, 9'h000, 2'd1, 9'h10D, 9'h001, 2'd1, 9'h10D, 1, 0, 0, 16'd1};
      tbl[5]  = '{0, 0, 0, 9'h000, 2'd0, 9'h0AA, 9'h002, 2'd0, 9'h0AA, 1, 0, 0, 16'd2};
      tbl[6]  = '{0, 0, 1, 9'h1F0, 2'd2, 9'h003, 9'h1F0, 2'd2, 9'h003, 1, 0, 0, 16'd3};
      tbl[7]  = '{0, 0, 0, 9'h000, 2'd0, 9'h000, 9'h1F1, 2'd0, 9'h000, 1, 0, 0, 16'd4};
      tbl[8]  = '{0, 1, 1, 9'h055, 2'd3, 9'h1FF, 9'h1F1, 2'd0, 9'h000, 0, 1, 0, 16'd5};
      tbl[9]  = '{0, 0, 0, 9'h000, 2'd0, 9'h000, 9'h1F1, 2'd0, 9'h000, 0, 1, 0, 16'd5};
      tbl[10] = '{1, 0, 0, 9'h000, 2'd0, 9'h000, 9'h000, 2'd0, 9'h000, 0, 0, 0, 16'd0};
      tbl[11] = '{0, 0, 0, 9'h000, 2'd0, 9'h000, 9'h000, 2'd0, 9'h000, 1, 0, 0, 16'd0};

      #12;
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
      Reset_n = 1'b1;
      tick();
      chk_all("idle", 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].start, tbl[i].ack, tbl[i].br, tbl[i].tgt, tbl[i].ns, tbl[i].pio);
         tick();
         chk_all($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].cs, tbl[i].prev, tbl[i].run,
                 tbl[i].done, tbl[i].tmo, tbl[i].cyc);
      end

      // Asynchronous reset mid-RUN at PC 37.
      go_run();
      drive(0, 0, 1, 9'd37, 2'd1, 9'h055);
      tick();
      chk("areset.pre_pc", 32'(ProgCtr), 37);
      drive(0, 0, 0, 0, 0, 0);
      #2 Reset_n = 1'b0;
      #1 chk_all("areset", 0, 0, 0, 0, 0, 0, 0);
      #1 Reset_n = 1'b1;
      tick();
      chk_all("areset.idle", 0, 0, 0, 0, 0, 0, 0);

      // Six-cycle program ending in Ack.
      go_run();
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("ack6.pc%0d", i), 32'(ProgCtr), i);
         drive(0, i == 5, 0, 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      chk_all("ack6.end", 5, 0, 0, 0, 1, 0, 6);

      // Branch at PC 4, then wrap from 0x1FF.
      go_run();
      repeat (4) tick();
      chk("br.pc4", 32'(ProgCtr), 4);
      drive(0, 0, 1, 9'h1F0, 0, 0);
      tick();
      chk("br.tgt", 32'(ProgCtr), 32'h1F0);
      go_run();
      drive(0, 0, 1, 9'h1FF, 0, 0);
      tick();
      chk("wrap.pre", 32'(ProgCtr), 32'h1FF);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("wrap.post", 32'(ProgCtr), 0);

      // Watchdog expiry after MAXC RUN cycles.
      go_run();
      repeat (MAXC - 1) tick();
      chk("wd.run7", 32'(Run), 1);
      tick();
      chk_all("wd.end", MAXC - 1, 0, 0, 0, 1, 1, MAXC);
      tick();
      chk_all("wd.hold", MAXC - 1, 0, 0, 0, 1, 1, MAXC);
      drive(1, 0, 0, 0, 0, 0);
      tick();
      chk_all("wd.restart", 0, 0, 0, 0, 0, 0, 0);

      // Ack coincident with watchdog expiry.
      drive(0, 0, 0, 0, 0, 0);
      tick();
      repeat (MAXC - 1) tick();
      drive(0, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk_all("ackwd", MAXC - 1, 0, 0, 0, 1, 0, MAXC);

      // Abort at PC 12.
      go_run();
      drive(0, 0, 1, 9'd12, 0, 0);
      tick();
      chk("abort.pc12", 32'(ProgCtr), 12);
      drive(1, 0, 0, 0, 0, 0);
      tick();
      chk_all("abort.load", 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk_all("abort.rerun", 0, 0, 0, 1, 0, 0, 0);
      tick();
      chk_all("abort.step", 1, 0, 0, 1, 0, 0, 1);

      // Random programs against an array-based reference of the program trace.
      for (int p = 0; p < 30; p++) begin
         int k, e;
         bit brs[MAXC];
         int tgts[MAXC], nss[MAXC], pios[MAXC], pcs[MAXC+1];
         k = $urandom_range(11);          // ack cycle; >= MAXC means no ack
         e = (k < MAXC - 1) ? k : MAXC - 1;
         for (int i = 0; i < MAXC; i++) begin
            brs[i]  = ($urandom_range(3) == 0);
            tgts[i] = $urandom_range(511);
            nss[i]  = $urandom_range(3);
            pios[i] = $urandom_range(511);
         end
         pcs[0] = 0;
         for (int i = 0; i < MAXC; i++) pcs[i+1] = brs[i] ? tgts[i] : (pcs[i] + 1) % 512;

         drive(1, 0, 0, 0, 0, 0);
         repeat ($urandom_range(1, 3)) tick();
         drive(0, 0, 0, 0, 0, 0);
         tick();
         for (int i = 0; i <= e; i++) begin
            chk("rnd.pc", 32'(ProgCtr), pcs[i]);
            chk("rnd.run", 32'(Run), 1);
            drive(0, i == k, brs[i], 9'(tgts[i]), 2'(nss[i]), 9'(pios[i]));
            tick();
         end
         drive(0, 0, 0, 0, 0, 0);
         chk_all($sformatf("rnd%0d.end", p), pcs[e], (e > 0) ? nss[e-1] : 0,
                 (e > 0) ? pios[e-1] : 0, 0, 1, (k > MAXC - 1) ? 1 : 0, e + 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
